// File: rtl/idct_8x8_engine.sv
// Serial 8x8 inverse DCT: loads 64 coefficients, then rebuilds each pixel
// with 64 multiply-accumulate steps through a 2-stage product/accumulate pipe.
module idct_8x8_engine #(
    parameter int COEF_W      = 16,
    parameter int PIX_W       = 8,
    parameter int ACC_W       = 48,
    parameter int LEVEL_SHIFT = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [COEF_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PIX_W-1:0]  out_data,
    output logic              busy
);
    typedef enum logic [1:0] {LOAD, COMPUTE, EMIT} state_t;

    localparam logic signed [ACC_W-1:0] HALF    = ACC_W'(1) <<< 23;
    localparam logic signed [ACC_W-1:0] LVL     = ACC_W'(LEVEL_SHIFT);
    localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << PIX_W) - 1);

    state_t state, state_nx;
    logic [5:0] idx, pix;
    logic [6:0] cnt;
    logic [COEF_W-1:0] coef_mem [64];
    logic signed [ACC_W-1:0] acc, prod_q, prod_c;
    logic signed [ACC_W-1:0] coef_x, alpha_x, c1_x, c2_x, rnd, lvl;
    logic prod_vld, issue, done, in_fire, out_fire;
    logic [PIX_W-1:0] pix_sat;
    logic [2:0] k1, k2;
    logic [6:0] alpha;

    // Q8 cos(pi*(2n+1)*k/16); the angle index folds modulo 32 with a sign flip past 16.
    function automatic logic signed [9:0] cos_q8(input logic [2:0] n, input logic [2:0] k);
        logic [6:0] m;
        logic signed [9:0] v;
        m = 7'({n, 1'b1}) * 7'(k);
        case (m[3:0])
            4'd0:  v = 10'sd256;
            4'd1:  v = 10'sd251;
            4'd2:  v = 10'sd236;
            4'd3:  v = 10'sd213;
            4'd4:  v = 10'sd181;
            4'd5:  v = 10'sd142;
            4'd6:  v = 10'sd98;
            4'd7:  v = 10'sd50;
            4'd8:  v = 10'sd0;
            4'd9:  v = -10'sd50;
            4'd10: v = -10'sd98;
            4'd11: v = -10'sd142;
            4'd12: v = -10'sd181;
            4'd13: v = -10'sd213;
            4'd14: v = -10'sd236;
            default: v = -10'sd251;
        endcase
        return m[4] ? -v : v;
    endfunction

    assign in_ready  = (state == LOAD);
    assign out_valid = (state == EMIT);
    assign busy      = (state != LOAD);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_ready && out_valid;
    assign issue     = (state == COMPUTE) && (cnt < 7'd64);
    assign done      = (state == COMPUTE) && (cnt == 7'd66);

    always_comb begin
        state_nx = state;
        case (state)
            LOAD:    if (in_fire && idx == 6'd63) state_nx = COMPUTE;
            COMPUTE: if (done) state_nx = EMIT;
            EMIT:    if (out_fire) state_nx = (pix == 6'd63) ? LOAD : COMPUTE;
            default: state_nx = LOAD;
        endcase
    end

    always_comb begin
        k1      = cnt[5:3];
        k2      = cnt[2:0];
        alpha   = (k1 == 3'd0 && k2 == 3'd0) ? 7'd32 :
                  (k1 == 3'd0 || k2 == 3'd0) ? 7'd45 : 7'd64;
        coef_x  = ACC_W'($signed(coef_mem[cnt[5:0]]));
        alpha_x = ACC_W'($signed({1'b0, alpha}));
        c1_x    = ACC_W'(cos_q8(pix[5:3], k1));
        c2_x    = ACC_W'(cos_q8(pix[2:0], k2));
        prod_c  = coef_x * alpha_x * c1_x * c2_x;
    end

    // Round half-up out of Q24, level shift, then clamp to the pixel range.
    always_comb begin
        rnd = (acc + HALF) >>> 24;
        lvl = rnd + LVL;
        if (lvl[ACC_W-1])      pix_sat = '0;
        else if (lvl > PIX_MAX) pix_sat = '1;
        else                    pix_sat = lvl[PIX_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= LOAD;
            idx      <= '0;
            pix      <= '0;
            cnt      <= '0;
            acc      <= '0;
            prod_q   <= '0;
            prod_vld <= 1'b0;
            out_data <= '0;
        end else begin
            state    <= state_nx;
            prod_vld <= issue;
            if (in_fire) idx <= idx + 6'd1;
            cnt <= (state == COMPUTE) ? cnt + 7'd1 : 7'd0;
            if (issue) prod_q <= prod_c;
            // Pipe is empty when term 0 issues, so clearing here drops nothing.
            if (issue && cnt == 7'd0) acc <= '0;
            else if (prod_vld)        acc <= acc + prod_q;
            if (done)     out_data <= pix_sat;
            if (out_fire) pix <= pix + 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) coef_mem[idx] <= in_data;
    end
endmodule

// File: tb/tb_idct_8x8_engine.sv
// Scoreboard bench for idct_8x8_engine: expected pixels are queued when a block
// is sent and popped as the engine emits them.
module tb_idct_8x8_engine;
    typedef logic signed [15:0] blk_t [64];

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready, out_valid, busy;
    logic [7:0]  out_data;

    int n_cmp = 0, n_err = 0;
    int sb[$];
    int tol = 0;
    int ir_toggles = 0;
    logic ir_prev = 1'b1;

    always #5 clk = ~clk;

    idct_8x8_engine #(.COEF_W(16), .PIX_W(8), .ACC_W(48), .LEVEL_SHIFT(128)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy)
    );

    always @(negedge clk) begin
        if (in_ready !== ir_prev) ir_toggles++;
        ir_prev = in_ready;
    end

    function automatic int golden(input blk_t c, input int n1, input int n2);
        real s, a1, a2, v, pi;
        pi = 3.14159265358979;
        s = 0.0;
        for (int k1 = 0; k1 < 8; k1++)
            for (int k2 = 0; k2 < 8; k2++) begin
                a1 = (k1 == 0) ? 0.35355339 : 0.5;
                a2 = (k2 == 0) ? 0.35355339 : 0.5;
                s += real'(c[k1*8+k2]) * a1 * a2 * $cos(pi*(2*n1+1)*k1/16.0)
                     * $cos(pi*(2*n2+1)*k2/16.0);
            end
        v = $floor(s + 128.0 + 0.5);
        if (v < 0.0) v = 0.0;
        if (v > 255.0) v = 255.0;
        return int'(v);
    endfunction

    task automatic send_block(input blk_t c, input bit hold);
        int i = 0, guard = 0;
        bit fire;
        while (i < 64) begin
            in_valid = 1'b1;
            in_data  = c[i];
            fire     = in_ready;
            @(negedge clk);
            if (fire) begin
                i++;
                guard = 0;
            end else if (++guard > 300) begin
                n_cmp++; n_err++;
                $display("FAIL in_ready_timeout coef=%0d got=0 want=1", i);
                break;
            end
        end
        if (!hold) in_valid = 1'b0;
    endtask

    // Collects n pixels; checks values, first-valid latency, hold-under-stall and in_ready.
    task automatic recv_pixels(input int n, input int ready_pct);
        int got = 0, idle = 0, lat = 0, want, diff;
        bit pend = 1'b1, stall = 1'b0, rdy;
        logic [7:0] held = '0;
        while (got < n) begin
            rdy = ($urandom_range(0, 99) < ready_pct);
            out_ready = rdy;
            if (out_valid) begin
                idle = 0;
                if (pend) begin
                    n_cmp++;
                    if (lat !== 67) begin
                        n_err++;
                        $display("FAIL latency pix=%0d got=%0d want=67", got, lat);
                    end
                    pend = 1'b0;
                end
                if (stall) begin
                    n_cmp++;
                    if (out_data !== held) begin
                        n_err++;
                        $display("FAIL hold_stable got=%0d want=%0d", out_data, held);
                    end
                end
                n_cmp++;
                if (in_ready !== 1'b0 || busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL emit_flags in_ready=%b busy=%b want 0/1", in_ready, busy);
                end
                if (rdy) begin
                    want = (sb.size() > 0) ? sb.pop_front() : -1;
                    diff = int'(out_data) - want;
                    n_cmp++;
                    if ((tol == 0) ? (int'(out_data) !== want) : (diff > tol || diff < -tol)) begin
                        n_err++;
                        $display("FAIL pixel_%0d got=%0d want=%0d", got, out_data, want);
                    end
                    got++;
                    stall = 1'b0;
                    pend  = 1'b1;
                    lat   = 0;
                end else begin
                    stall = 1'b1;
                    held  = out_data;
                end
            end else begin
                if (pend) lat++;
                if (++idle > 300) begin
                    n_cmp++; n_err++;
                    $display("FAIL out_valid_timeout pix=%0d got=0 want=1", got);
                    break;
                end
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
    endtask

    function automatic blk_t dc_block(input int dc);
        blk_t b;
        for (int i = 0; i < 64; i++) b[i] = '0;
        b[0] = 16'(dc);
        return b;
    endfunction

    task automatic test_reset;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'd0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state got=%b%b%0d%b want=1,0,0,0", in_ready, out_valid, out_data, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero;
        tol = 0;
        repeat (64) sb.push_back(128);
        send_block(dc_block(0), 1'b0);
        recv_pixels(64, 100);
    endtask

    task automatic test_dc_sat;
        int dcs[3] = '{256, 2047, -2048};
        int vals[3] = '{160, 255, 0};
        tol = 0;
        for (int j = 0; j < 3; j++) begin
            repeat (64) sb.push_back(vals[j]);
            send_block(dc_block(dcs[j]), 1'b0);
            recv_pixels(64, 100);
        end
    endtask

    task automatic test_ac(input int ready_pct);
        blk_t b;
        int row[8] = '{152, 69, 187, 104, 104, 187, 69, 152};
        tol = 0;
        b = dc_block(0);
        b[6] = 16'sd362;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) sb.push_back(row[c]);
        send_block(b, 1'b0);
        recv_pixels(64, ready_pct);
    endtask

    task automatic test_reset_mid;
        bit bad = 1'b0;
        tol = 0;
        repeat (64) sb.push_back(160);
        send_block(dc_block(256), 1'b0);
        recv_pixels(20, 100);
        repeat (10) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL mid_compute busy=%b out_valid=%b want 1/0", busy, out_valid);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'd0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset got=%b%b%0d%b want=1,0,0,0", in_ready, out_valid, out_data, busy);
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (64) sb.push_back(160);
        send_block(dc_block(256), 1'b0);
        recv_pixels(64, 100);
        repeat (100) begin
            if (out_valid !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        n_cmp++;
        if (bad || sb.size() != 0) begin
            n_err++;
            $display("FAIL stale_pixels got=%b/%0d want=0/0", bad, sb.size());
        end
    endtask

    task automatic test_back_to_back;
        blk_t b;
        tol = 1;
        ir_toggles = 0;
        for (int j = 0; j < 3; j++) begin
            b = dc_block(int'($urandom_range(0, 800)) - 400);
            for (int q = 0; q < 3; q++)
                b[$urandom_range(1, 63)] = 16'(int'($urandom_range(0, 80)) - 40);
            for (int p = 0; p < 64; p++) sb.push_back(golden(b, p / 8, p % 8));
            send_block(b, 1'b1);
            recv_pixels(64, 100);
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (ir_toggles !== 6) begin
            n_err++;
            $display("FAIL in_ready_toggles got=%0d want=6", ir_toggles);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_zero();
        test_dc_sat();
        test_ac(100);
        test_ac(30);
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
